// File: rtl/axi_master_arbiter.sv
// axi_master_arbiter
// Single-outstanding AXI4 master shared by an instruction-fetch client (IFU,
// read-only) and a load/store client (LSU, read/write). One request is granted
// in IDLE, latched, driven as a single-beat AXI transaction, and answered with
// a one-cycle response pulse on the originating client's port.
module axi_master_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned IFU_ID = 0,
  parameter int unsigned LSU_ID = 1,
  parameter bit          ARB_RR = 1'b1
) (
  input  logic                  clock_i,
  input  logic                  reset_i,   // asynchronous, active-low

  // IFU client (read-only)
  input  logic                  ifu_req_valid_i,
  output logic                  ifu_req_ready_o,
  input  logic [ADDR_W-1:0]     ifu_addr_i,
  output logic                  ifu_rsp_valid_o,
  output logic [DATA_W-1:0]     ifu_rsp_data_o,
  output logic                  ifu_rsp_err_o,

  // LSU client (read/write)
  input  logic                  lsu_req_valid_i,
  output logic                  lsu_req_ready_o,
  input  logic                  lsu_req_wen_i,
  input  logic [ADDR_W-1:0]     lsu_addr_i,
  input  logic [DATA_W-1:0]     lsu_wdata_i,
  input  logic [DATA_W/8-1:0]   lsu_wstrb_i,
  input  logic [2:0]            lsu_size_i,
  output logic                  lsu_rsp_valid_o,
  output logic [DATA_W-1:0]     lsu_rsp_data_o,
  output logic                  lsu_rsp_err_o,

  // AXI write address channel
  output logic                  io_master_awvalid_o,
  output logic [ADDR_W-1:0]     io_master_awaddr_o,
  output logic [ID_W-1:0]       io_master_awid_o,
  output logic [7:0]            io_master_awlen_o,
  output logic [2:0]            io_master_awsize_o,
  output logic [1:0]            io_master_awburst_o,
  input  logic                  io_master_awready_i,

  // AXI write data channel
  output logic                  io_master_wvalid_o,
  output logic [DATA_W-1:0]     io_master_wdata_o,
  output logic [DATA_W/8-1:0]   io_master_wstrb_o,
  output logic                  io_master_wlast_o,
  input  logic                  io_master_wready_i,

  // AXI write response channel
  output logic                  io_master_bready_o,
  input  logic                  io_master_bvalid_i,
  input  logic [1:0]            io_master_bresp_i,
  input  logic [ID_W-1:0]       io_master_bid_i,

  // AXI read address channel
  output logic                  io_master_arvalid_o,
  output logic [ADDR_W-1:0]     io_master_araddr_o,
  output logic [ID_W-1:0]       io_master_arid_o,
  output logic [7:0]            io_master_arlen_o,
  output logic [2:0]            io_master_arsize_o,
  output logic [1:0]            io_master_arburst_o,
  input  logic                  io_master_arready_i,

  // AXI read data channel
  output logic                  io_master_rready_o,
  input  logic                  io_master_rvalid_i,
  input  logic [DATA_W-1:0]     io_master_rdata_i,
  input  logic [1:0]            io_master_rresp_i,
  input  logic                  io_master_rlast_i,
  input  logic [ID_W-1:0]       io_master_rid_i
);

  localparam int unsigned     STRB_W     = DATA_W / 8;
  localparam logic [2:0]      IFU_SIZE   = 3'($clog2(STRB_W));
  localparam logic [ID_W-1:0] IFU_AXI_ID = ID_W'(IFU_ID);
  localparam logic [ID_W-1:0] LSU_AXI_ID = ID_W'(LSU_ID);
  localparam logic [1:0]      BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR_REQ,
    ST_WR_RESP
  } state_e;

  typedef enum logic {
    CL_IFU = 1'b0,
    CL_LSU = 1'b1
  } client_e;

  state_e              state_q, state_d;
  client_e             client_q, client_d;
  client_e             last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [2:0]          size_q, size_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;

  logic                ifu_rsp_valid_q, ifu_rsp_valid_d;
  logic [DATA_W-1:0]   ifu_rsp_data_q, ifu_rsp_data_d;
  logic                ifu_rsp_err_q, ifu_rsp_err_d;
  logic                lsu_rsp_valid_q, lsu_rsp_valid_d;
  logic [DATA_W-1:0]   lsu_rsp_data_q, lsu_rsp_data_d;
  logic                lsu_rsp_err_q, lsu_rsp_err_d;

  logic [ID_W-1:0]     expect_id;
  logic                rd_err;

  // The ID the granted client's read must come back with.
  assign expect_id = (client_q == CL_LSU) ? LSU_AXI_ID : IFU_AXI_ID;

  // Fixed single-beat INCR fields; addresses and payload come from the latch.
  assign io_master_awaddr_o  = addr_q;
  assign io_master_awid_o    = LSU_AXI_ID;
  assign io_master_awlen_o   = 8'd0;
  assign io_master_awsize_o  = size_q;
  assign io_master_awburst_o = BURST_INCR;
  assign io_master_wdata_o   = wdata_q;
  assign io_master_wstrb_o   = wstrb_q;
  assign io_master_wlast_o   = io_master_wvalid_o;
  assign io_master_araddr_o  = addr_q;
  assign io_master_arid_o    = expect_id;
  assign io_master_arlen_o   = 8'd0;
  assign io_master_arsize_o  = size_q;
  assign io_master_arburst_o = BURST_INCR;

  assign ifu_rsp_valid_o = ifu_rsp_valid_q;
  assign ifu_rsp_data_o  = ifu_rsp_data_q;
  assign ifu_rsp_err_o   = ifu_rsp_err_q;
  assign lsu_rsp_valid_o = lsu_rsp_valid_q;
  assign lsu_rsp_data_o  = lsu_rsp_data_q;
  assign lsu_rsp_err_o   = lsu_rsp_err_q;

  // Next-state, grant and AXI handshake logic.
  always_comb begin
    // NOTE: every variable written here gets a default before the case, so
    // no path through the decode can leave one unassigned and infer a latch.
    state_d             = state_q;
    client_d            = client_q;
    last_grant_d        = last_grant_q;
    addr_d              = addr_q;
    wdata_d             = wdata_q;
    wstrb_d             = wstrb_q;
    size_d              = size_q;
    aw_done_d           = aw_done_q;
    w_done_d            = w_done_q;
    ifu_rsp_valid_d     = 1'b0;
    ifu_rsp_data_d      = ifu_rsp_data_q;
    ifu_rsp_err_d       = ifu_rsp_err_q;
    lsu_rsp_valid_d     = 1'b0;
    lsu_rsp_data_d      = lsu_rsp_data_q;
    lsu_rsp_err_d       = lsu_rsp_err_q;
    rd_err              = 1'b0;
    ifu_req_ready_o     = 1'b0;
    lsu_req_ready_o     = 1'b0;
    io_master_arvalid_o = 1'b0;
    io_master_rready_o  = 1'b0;
    io_master_awvalid_o = 1'b0;
    io_master_wvalid_o  = 1'b0;
    io_master_bready_o  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // LSU wins when alone, under fixed priority, or when IFU went last.
        if (lsu_req_valid_i &&
            (!ifu_req_valid_i || !ARB_RR || last_grant_q == CL_IFU)) begin
          lsu_req_ready_o = 1'b1;
          client_d        = CL_LSU;
          last_grant_d    = CL_LSU;
          addr_d          = lsu_addr_i;
          wdata_d         = lsu_wdata_i;
          wstrb_d         = lsu_wstrb_i;
          size_d          = lsu_size_i;
          aw_done_d       = 1'b0;
          w_done_d        = 1'b0;
          state_d         = lsu_req_wen_i ? ST_WR_REQ : ST_RD_ADDR;
        end else if (ifu_req_valid_i) begin
          ifu_req_ready_o = 1'b1;
          client_d        = CL_IFU;
          last_grant_d    = CL_IFU;
          addr_d          = ifu_addr_i;
          size_d          = IFU_SIZE;
          state_d         = ST_RD_ADDR;
        end
      end

      ST_RD_ADDR: begin
        io_master_arvalid_o = 1'b1;
        if (io_master_arready_i) begin
          state_d = ST_RD_DATA;
        end
      end

      ST_RD_DATA: begin
        io_master_rready_o = 1'b1;
        if (io_master_rvalid_i) begin
          rd_err = (io_master_rresp_i != 2'b00) ||
                   (io_master_rid_i != expect_id) ||
                   !io_master_rlast_i;
          if (client_q == CL_LSU) begin
            lsu_rsp_valid_d = 1'b1;
            lsu_rsp_data_d  = io_master_rdata_i;
            lsu_rsp_err_d   = rd_err;
          end else begin
            ifu_rsp_valid_d = 1'b1;
            ifu_rsp_data_d  = io_master_rdata_i;
            ifu_rsp_err_d   = rd_err;
          end
          state_d = ST_IDLE;
        end
      end

      ST_WR_REQ: begin
        // AW and W complete independently; each valid drops after its own beat.
        io_master_awvalid_o = !aw_done_q;
        io_master_wvalid_o  = !w_done_q;
        aw_done_d = aw_done_q || io_master_awready_i;
        w_done_d  = w_done_q  || io_master_wready_i;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = ST_WR_RESP;
        end
      end

      ST_WR_RESP: begin
        io_master_bready_o = 1'b1;
        if (io_master_bvalid_i) begin
          lsu_rsp_valid_d = 1'b1;
          lsu_rsp_data_d  = '0;
          lsu_rsp_err_d   = (io_master_bresp_i != 2'b00) ||
                            (io_master_bid_i != LSU_AXI_ID);
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, request latch and response registers; reset abandons any transfer.
  always_ff @(posedge clock_i or negedge reset_i) begin
    // NOTE: non-blocking assignments make every register sample pre-edge
    // values, independent of statement order.
    if (!reset_i) begin
      state_q         <= ST_IDLE;
      client_q        <= CL_IFU;
      last_grant_q    <= CL_IFU;
      addr_q          <= '0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      size_q          <= '0;
      aw_done_q       <= 1'b0;
      w_done_q        <= 1'b0;
      ifu_rsp_valid_q <= 1'b0;
      ifu_rsp_data_q  <= '0;
      ifu_rsp_err_q   <= 1'b0;
      lsu_rsp_valid_q <= 1'b0;
      lsu_rsp_data_q  <= '0;
      lsu_rsp_err_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      client_q        <= client_d;
      last_grant_q    <= last_grant_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      wstrb_q         <= wstrb_d;
      size_q          <= size_d;
      aw_done_q       <= aw_done_d;
      w_done_q        <= w_done_d;
      ifu_rsp_valid_q <= ifu_rsp_valid_d;
      ifu_rsp_data_q  <= ifu_rsp_data_d;
      ifu_rsp_err_q   <= ifu_rsp_err_d;
      lsu_rsp_valid_q <= lsu_rsp_valid_d;
      lsu_rsp_data_q  <= lsu_rsp_data_d;
      lsu_rsp_err_q   <= lsu_rsp_err_d;
    end
  end

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Directed bench for axi_master_arbiter: a 32-bit round-robin instance (u0)
// and a 64-bit fixed-priority instance (u1), each driven by hand-timed slave
// stimulus. Inputs change #1 after the falling edge; outputs are sampled then.
module tb_axi_master_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int assertions = 0;
  int failures   = 0;

  // ---------------- u0: DATA_W=32, ARB_RR=1 ----------------
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
  logic [31:0] ifu_addr, ifu_rsp_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_rsp_valid, lsu_rsp_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rsp_data;
  logic [3:0]  lsu_wstrb;
  logic [2:0]  lsu_size;
  logic        awvalid, awready, wvalid, wready, wlast, bready, bvalid;
  logic        arvalid, arready, rready, rvalid, rlast;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0]  awid, arid, bid, rid, wstrb;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;

  // ---------------- u1: DATA_W=64, ARB_RR=0 ----------------
  logic        b_ifu_req_valid, b_ifu_req_ready, b_ifu_rsp_valid, b_ifu_rsp_err;
  logic [31:0] b_ifu_addr;
  logic [63:0] b_ifu_rsp_data;
  logic        b_lsu_req_valid, b_lsu_req_ready, b_lsu_req_wen, b_lsu_rsp_valid, b_lsu_rsp_err;
  logic [31:0] b_lsu_addr;
  logic [63:0] b_lsu_wdata, b_lsu_rsp_data;
  logic [7:0]  b_lsu_wstrb;
  logic [2:0]  b_lsu_size;
  logic        b_awvalid, b_awready, b_wvalid, b_wready, b_wlast, b_bready, b_bvalid;
  logic        b_arvalid, b_arready, b_rready, b_rvalid, b_rlast;
  logic [31:0] b_awaddr, b_araddr;
  logic [63:0] b_wdata, b_rdata;
  logic [7:0]  b_wstrb;
  logic [3:0]  b_awid, b_arid, b_bid, b_rid;
  logic [7:0]  b_awlen, b_arlen;
  logic [2:0]  b_awsize, b_arsize;
  logic [1:0]  b_awburst, b_arburst, b_bresp, b_rresp;

  axi_master_arbiter #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .IFU_ID(0), .LSU_ID(1), .ARB_RR(1'b1)) u0 (
    .clock_i(clk), .reset_i(rst_n),
    .ifu_req_valid_i(ifu_req_valid), .ifu_req_ready_o(ifu_req_ready), .ifu_addr_i(ifu_addr),
    .ifu_rsp_valid_o(ifu_rsp_valid), .ifu_rsp_data_o(ifu_rsp_data), .ifu_rsp_err_o(ifu_rsp_err),
    .lsu_req_valid_i(lsu_req_valid), .lsu_req_ready_o(lsu_req_ready), .lsu_req_wen_i(lsu_req_wen),
    .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata), .lsu_wstrb_i(lsu_wstrb), .lsu_size_i(lsu_size),
    .lsu_rsp_valid_o(lsu_rsp_valid), .lsu_rsp_data_o(lsu_rsp_data), .lsu_rsp_err_o(lsu_rsp_err),
    .io_master_awvalid_o(awvalid), .io_master_awaddr_o(awaddr), .io_master_awid_o(awid),
    .io_master_awlen_o(awlen), .io_master_awsize_o(awsize), .io_master_awburst_o(awburst),
    .io_master_awready_i(awready),
    .io_master_wvalid_o(wvalid), .io_master_wdata_o(wdata), .io_master_wstrb_o(wstrb),
    .io_master_wlast_o(wlast), .io_master_wready_i(wready),
    .io_master_bready_o(bready), .io_master_bvalid_i(bvalid), .io_master_bresp_i(bresp), .io_master_bid_i(bid),
    .io_master_arvalid_o(arvalid), .io_master_araddr_o(araddr), .io_master_arid_o(arid),
    .io_master_arlen_o(arlen), .io_master_arsize_o(arsize), .io_master_arburst_o(arburst),
    .io_master_arready_i(arready),
    .io_master_rready_o(rready), .io_master_rvalid_i(rvalid), .io_master_rdata_i(rdata),
    .io_master_rresp_i(rresp), .io_master_rlast_i(rlast), .io_master_rid_i(rid)
  );

  axi_master_arbiter #(.ADDR_W(32), .DATA_W(64), .ID_W(4), .IFU_ID(0), .LSU_ID(1), .ARB_RR(1'b0)) u1 (
    .clock_i(clk), .reset_i(rst_n),
    .ifu_req_valid_i(b_ifu_req_valid), .ifu_req_ready_o(b_ifu_req_ready), .ifu_addr_i(b_ifu_addr),
    .ifu_rsp_valid_o(b_ifu_rsp_valid), .ifu_rsp_data_o(b_ifu_rsp_data), .ifu_rsp_err_o(b_ifu_rsp_err),
    .lsu_req_valid_i(b_lsu_req_valid), .lsu_req_ready_o(b_lsu_req_ready), .lsu_req_wen_i(b_lsu_req_wen),
    .lsu_addr_i(b_lsu_addr), .lsu_wdata_i(b_lsu_wdata), .lsu_wstrb_i(b_lsu_wstrb), .lsu_size_i(b_lsu_size),
    .lsu_rsp_valid_o(b_lsu_rsp_valid), .lsu_rsp_data_o(b_lsu_rsp_data), .lsu_rsp_err_o(b_lsu_rsp_err),
    .io_master_awvalid_o(b_awvalid), .io_master_awaddr_o(b_awaddr), .io_master_awid_o(b_awid),
    .io_master_awlen_o(b_awlen), .io_master_awsize_o(b_awsize), .io_master_awburst_o(b_awburst),
    .io_master_awready_i(b_awready),
    .io_master_wvalid_o(b_wvalid), .io_master_wdata_o(b_wdata), .io_master_wstrb_o(b_wstrb),
    .io_master_wlast_o(b_wlast), .io_master_wready_i(b_wready),
    .io_master_bready_o(b_bready), .io_master_bvalid_i(b_bvalid), .io_master_bresp_i(b_bresp), .io_master_bid_i(b_bid),
    .io_master_arvalid_o(b_arvalid), .io_master_araddr_o(b_araddr), .io_master_arid_o(b_arid),
    .io_master_arlen_o(b_arlen), .io_master_arsize_o(b_arsize), .io_master_arburst_o(b_arburst),
    .io_master_arready_i(b_arready),
    .io_master_rready_o(b_rready), .io_master_rvalid_i(b_rvalid), .io_master_rdata_i(b_rdata),
    .io_master_rresp_i(b_rresp), .io_master_rlast_i(b_rlast), .io_master_rid_i(b_rid)
  );

  // Captured AR fields from the last slave_read on u0.
  logic [31:0] seen_araddr;
  logic [3:0]  seen_arid;
  logic [2:0]  seen_arsize;

  // Zero-wait read slave for u0. Called #1 after the grant edge; returns #1
  // after the falling edge of the response-pulse cycle.
  task automatic slave_read(input logic [3:0] id_v, input logic [31:0] data_v,
                            input logic [1:0] resp_v, input logic last_v, input bit keep_req);
    int n;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!arvalid && n < 8);
    assertions++;
    if (arvalid !== 1'b1) begin failures++; $display("FAIL rd_arvalid_timeout: arvalid=%b want 1", arvalid); end
    if (!keep_req) begin ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; end
    seen_araddr = araddr; seen_arid = arid; seen_arsize = arsize;
    arready = 1'b1;
    @(negedge clk); #1;
    arready = 1'b0;
    rvalid = 1'b1; rdata = data_v; rresp = resp_v; rid = id_v; rlast = last_v;
    n = 0;
    while (!rready && n < 8) begin @(negedge clk); #1; n++; end
    assertions++;
    if (rready !== 1'b1) begin failures++; $display("FAIL rd_rready_timeout: rready=%b want 1", rready); end
    @(negedge clk); #1;
    rvalid = 1'b0; rlast = 1'b0; rid = '0; rresp = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifu_req_valid = 0; ifu_addr = '0; lsu_req_valid = 0; lsu_req_wen = 0; lsu_addr = '0;
    lsu_wdata = '0; lsu_wstrb = '0; lsu_size = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = '0; bid = '0;
    arready = 0; rvalid = 0; rdata = '0; rresp = '0; rlast = 0; rid = '0;
    b_ifu_req_valid = 0; b_ifu_addr = '0; b_lsu_req_valid = 0; b_lsu_req_wen = 0; b_lsu_addr = '0;
    b_lsu_wdata = '0; b_lsu_wstrb = '0; b_lsu_size = '0;
    b_awready = 0; b_wready = 0; b_bvalid = 0; b_bresp = '0; b_bid = '0;
    b_arready = 0; b_rvalid = 0; b_rdata = '0; b_rresp = '0; b_rlast = 0; b_rid = '0;
    repeat (2) @(negedge clk);
    #1;
    assertions++;
    if ({arvalid, awvalid, wvalid, bready, rready, ifu_rsp_valid, lsu_rsp_valid, ifu_rsp_err, lsu_rsp_err} !== 9'b0) begin
      failures++; $display("FAIL reset_ctrl_u0: flags=%b want 0",
        {arvalid, awvalid, wvalid, bready, rready, ifu_rsp_valid, lsu_rsp_valid, ifu_rsp_err, lsu_rsp_err});
    end
    assertions++;
    if ({ifu_rsp_data, lsu_rsp_data} !== 64'h0) begin
      failures++; $display("FAIL reset_data_u0: data=%h want 0", {ifu_rsp_data, lsu_rsp_data});
    end
    assertions++;
    if ({b_arvalid, b_awvalid, b_wvalid, b_bready, b_rready, b_ifu_rsp_valid, b_lsu_rsp_valid, b_ifu_rsp_data} !== 71'h0) begin
      failures++; $display("FAIL reset_u1: outputs nonzero (arv=%b awv=%b wv=%b data=%h)", b_arvalid, b_awvalid, b_wvalid, b_ifu_rsp_data);
    end
    rst_n = 1'b1;
    @(negedge clk); #1;
  endtask

  // Both clients requesting continuously: LSU first, then alternate.
  task automatic test_round_robin();
    bit exp_lsu;
    lsu_req_valid = 1; lsu_req_wen = 0; lsu_addr = 32'h0000_2000; lsu_size = 3'd2;
    ifu_req_valid = 1; ifu_addr = 32'h8000_0100;
    #1;
    for (int r = 0; r < 4; r++) begin
      exp_lsu = (r % 2 == 0);
      assertions++;
      if ({lsu_req_ready, ifu_req_ready} !== {exp_lsu, !exp_lsu}) begin
        failures++; $display("FAIL rr_grant_%0d: lsu_rdy,ifu_rdy=%b%b want %b%b", r, lsu_req_ready, ifu_req_ready, exp_lsu, !exp_lsu);
      end
      slave_read(exp_lsu ? 4'd1 : 4'd0, 32'hA000_0000 + r, 2'b00, 1'b1, 1'b1);
      assertions++;
      if (seen_araddr !== (exp_lsu ? 32'h0000_2000 : 32'h8000_0100)) begin
        failures++; $display("FAIL rr_araddr_%0d: araddr=%h", r, seen_araddr);
      end
      if (exp_lsu) begin
        assertions++;
        if ({lsu_rsp_valid, ifu_rsp_valid, lsu_rsp_err} !== 3'b100 || lsu_rsp_data !== 32'hA000_0000 + r) begin
          failures++; $display("FAIL rr_lsu_rsp_%0d: v=%b ifu_v=%b err=%b data=%h want 1 0 0 %h",
            r, lsu_rsp_valid, ifu_rsp_valid, lsu_rsp_err, lsu_rsp_data, 32'hA000_0000 + r);
        end
      end else begin
        assertions++;
        if ({ifu_rsp_valid, lsu_rsp_valid, ifu_rsp_err} !== 3'b100 || ifu_rsp_data !== 32'hA000_0000 + r) begin
          failures++; $display("FAIL rr_ifu_rsp_%0d: v=%b lsu_v=%b err=%b data=%h want 1 0 0 %h",
            r, ifu_rsp_valid, lsu_rsp_valid, ifu_rsp_err, ifu_rsp_data, 32'hA000_0000 + r);
        end
      end
    end
    ifu_req_valid = 0; lsu_req_valid = 0;
    @(negedge clk); #1;
  endtask

  // Cycle-exact IFU fetch against a zero-wait slave.
  task automatic test_ifu_read();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
    #1;
    assertions++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
      failures++; $display("FAIL ifu_grant: ifu_rdy,lsu_rdy=%b%b want 10", ifu_req_ready, lsu_req_ready);
    end
    @(negedge clk); #1;                                   // cycle 1
    assertions++;
    if (arvalid !== 1'b1 || araddr !== 32'h8000_0000 || arid !== 4'd0 || arsize !== 3'd2 ||
        arlen !== 8'd0 || arburst !== 2'b01) begin
      failures++; $display("FAIL ifu_ar: v=%b addr=%h id=%h size=%0d len=%0d burst=%b want 1 80000000 0 2 0 01",
        arvalid, araddr, arid, arsize, arlen, arburst);
    end
    assertions++;
    if (ifu_req_ready !== 1'b0) begin failures++; $display("FAIL ifu_busy_ready: ifu_req_ready=%b want 0", ifu_req_ready); end
    ifu_req_valid = 0; arready = 1;
    @(negedge clk); #1;                                   // cycle 2
    arready = 0;
    assertions++;
    if ({arvalid, rready, ifu_rsp_valid} !== 3'b010) begin
      failures++; $display("FAIL ifu_rdata_phase: arv,rrdy,rsp=%b want 010", {arvalid, rready, ifu_rsp_valid});
    end
    rvalid = 1; rdata = 32'h0000_0413; rresp = 2'b00; rid = 4'd0; rlast = 1;
    @(negedge clk); #1;                                   // cycle 3
    rvalid = 0; rlast = 0;
    assertions++;
    if ({ifu_rsp_valid, ifu_rsp_err, lsu_rsp_valid} !== 3'b100 || ifu_rsp_data !== 32'h0000_0413) begin
      failures++; $display("FAIL ifu_rsp: v=%b err=%b lsu_v=%b data=%h want 1 0 0 00000413",
        ifu_rsp_valid, ifu_rsp_err, lsu_rsp_valid, ifu_rsp_data);
    end
    @(negedge clk); #1;
    assertions++;
    if (ifu_rsp_valid !== 1'b0) begin failures++; $display("FAIL ifu_rsp_pulse: ifu_rsp_valid=%b want 0", ifu_rsp_valid); end
  endtask

  // LSU write with AWREADY arriving in the third AW cycle, WREADY immediate.
  task automatic test_write_delayed_aw();
    lsu_req_valid = 1; lsu_req_wen = 1; lsu_addr = 32'h0000_1000;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'b0011; lsu_size = 3'd2;
    #1;
    assertions++;
    if (lsu_req_ready !== 1'b1) begin failures++; $display("FAIL wr_grant: lsu_req_ready=%b want 1", lsu_req_ready); end
    @(negedge clk); #1;                                   // N1
    lsu_req_valid = 0;
    assertions++;
    if ({awvalid, wvalid, wlast} !== 3'b111 || awaddr !== 32'h0000_1000 || awid !== 4'd1 ||
        awsize !== 3'd2 || awburst !== 2'b01 || awlen !== 8'd0 || wdata !== 32'hDEAD_BEEF || wstrb !== 4'b0011) begin
      failures++; $display("FAIL wr_fields: awv=%b wv=%b wl=%b addr=%h id=%h size=%0d data=%h strb=%b",
        awvalid, wvalid, wlast, awaddr, awid, awsize, wdata, wstrb);
    end
    wready = 1;
    @(negedge clk); #1;                                   // N2
    wready = 0;
    assertions++;
    if ({awvalid, wvalid, wlast} !== 3'b100) begin
      failures++; $display("FAIL wr_w_drop: awv,wv,wlast=%b want 100", {awvalid, wvalid, wlast});
    end
    @(negedge clk); #1;                                   // N3
    assertions++;
    if ({awvalid, wvalid, bready} !== 3'b100) begin
      failures++; $display("FAIL wr_aw_hold: awv,wv,bready=%b want 100", {awvalid, wvalid, bready});
    end
    awready = 1;
    @(negedge clk); #1;                                   // N4
    awready = 0;
    assertions++;
    if ({awvalid, wvalid, bready, lsu_rsp_valid} !== 4'b0010) begin
      failures++; $display("FAIL wr_resp_wait: awv,wv,bready,rsp=%b want 0010", {awvalid, wvalid, bready, lsu_rsp_valid});
    end
    @(negedge clk); #1;                                   // N5
    assertions++;
    if ({bready, lsu_rsp_valid} !== 2'b10) begin
      failures++; $display("FAIL wr_no_early_rsp: bready,rsp=%b want 10", {bready, lsu_rsp_valid});
    end
    bvalid = 1; bresp = 2'b00; bid = 4'd1;
    @(negedge clk); #1;                                   // N6
    bvalid = 0;
    assertions++;
    if ({lsu_rsp_valid, lsu_rsp_err} !== 2'b10 || lsu_rsp_data !== 32'h0) begin
      failures++; $display("FAIL wr_rsp: v=%b err=%b data=%h want 1 0 00000000", lsu_rsp_valid, lsu_rsp_err, lsu_rsp_data);
    end
  endtask

  // Error reporting: bad BRESP, wrong RID, missing RLAST; then a clean read.
  task automatic test_errors();
    @(negedge clk); #1;
    lsu_req_valid = 1; lsu_req_wen = 1; lsu_addr = 32'h0000_1004; lsu_wdata = 32'h55; lsu_wstrb = 4'hF;
    @(negedge clk); #1;
    lsu_req_valid = 0;
    assertions++;
    if ({awvalid, wvalid} !== 2'b11) begin failures++; $display("FAIL err_wr_req: awv,wv=%b want 11", {awvalid, wvalid}); end
    awready = 1; wready = 1;
    @(negedge clk); #1;
    awready = 0; wready = 0;
    assertions++;
    if ({awvalid, wvalid, bready} !== 3'b001) begin
      failures++; $display("FAIL err_same_cycle_hs: awv,wv,bready=%b want 001", {awvalid, wvalid, bready});
    end
    bvalid = 1; bresp = 2'b10; bid = 4'd1;
    @(negedge clk); #1;
    bvalid = 0; bresp = 2'b00;
    assertions++;
    if ({lsu_rsp_valid, lsu_rsp_err} !== 2'b11) begin
      failures++; $display("FAIL err_bresp: v,err=%b want 11", {lsu_rsp_valid, lsu_rsp_err});
    end
    lsu_req_valid = 1; lsu_req_wen = 0; lsu_addr = 32'h0000_1008;
    #1;
    assertions++;
    if (lsu_req_ready !== 1'b1) begin failures++; $display("FAIL err_back_to_idle: lsu_req_ready=%b want 1", lsu_req_ready); end
    slave_read(4'd5, 32'h0000_0077, 2'b00, 1'b1, 1'b0);
    assertions++;
    if ({lsu_rsp_valid, lsu_rsp_err} !== 2'b11 || lsu_rsp_data !== 32'h77) begin
      failures++; $display("FAIL err_rid: v=%b err=%b data=%h want 1 1 00000077", lsu_rsp_valid, lsu_rsp_err, lsu_rsp_data);
    end
    ifu_req_valid = 1; ifu_addr = 32'h8000_0200;
    slave_read(4'd0, 32'h0000_0099, 2'b00, 1'b0, 1'b0);
    assertions++;
    if ({ifu_rsp_valid, ifu_rsp_err} !== 2'b11) begin
      failures++; $display("FAIL err_rlast: v,err=%b want 11", {ifu_rsp_valid, ifu_rsp_err});
    end
    ifu_req_valid = 1; ifu_addr = 32'h8000_0204;
    slave_read(4'd0, 32'h0000_00AA, 2'b00, 1'b1, 1'b0);
    assertions++;
    if ({ifu_rsp_valid, ifu_rsp_err} !== 2'b10 || ifu_rsp_data !== 32'hAA) begin
      failures++; $display("FAIL err_clear: v=%b err=%b data=%h want 1 0 000000aa", ifu_rsp_valid, ifu_rsp_err, ifu_rsp_data);
    end
  endtask

  // Reset asserted while RD_DATA sees a pending RVALID.
  task automatic test_reset_mid();
    @(negedge clk); #1;
    ifu_req_valid = 1; ifu_addr = 32'h8000_0040;
    @(negedge clk); #1;
    ifu_req_valid = 0; arready = 1;
    @(negedge clk); #1;
    arready = 0;
    rvalid = 1; rdata = 32'h0000_0BAD; rresp = 2'b00; rid = 4'd0; rlast = 1;
    assertions++;
    if (rready !== 1'b1) begin failures++; $display("FAIL rst_mid_setup: rready=%b want 1", rready); end
    #2 rst_n = 1'b0;
    #1;
    assertions++;
    if ({arvalid, rready, awvalid, wvalid, bready, ifu_rsp_valid, lsu_rsp_valid} !== 7'b0) begin
      failures++; $display("FAIL rst_mid_async: flags=%b want 0",
        {arvalid, rready, awvalid, wvalid, bready, ifu_rsp_valid, lsu_rsp_valid});
    end
    @(negedge clk);
    rst_n = 1'b1; rvalid = 0; rlast = 0;
    #1;
    assertions++;
    if ({ifu_rsp_valid, ifu_rsp_data} !== 33'h0) begin
      failures++; $display("FAIL rst_mid_no_pulse: v=%b data=%h want 0 0", ifu_rsp_valid, ifu_rsp_data);
    end
    @(negedge clk); #1;
    assertions++;
    if ({ifu_rsp_valid, rready} !== 2'b00) begin
      failures++; $display("FAIL rst_mid_quiet: v,rready=%b want 00", {ifu_rsp_valid, rready});
    end
    ifu_req_valid = 1; ifu_addr = 32'h8000_0044;
    #1;
    assertions++;
    if (ifu_req_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_regrant: ifu_req_ready=%b want 1", ifu_req_ready); end
    slave_read(4'd0, 32'h0000_0013, 2'b00, 1'b1, 1'b0);
    assertions++;
    if ({ifu_rsp_valid, ifu_rsp_err} !== 2'b10 || ifu_rsp_data !== 32'h13 || seen_araddr !== 32'h8000_0044) begin
      failures++; $display("FAIL rst_mid_resume: v=%b err=%b data=%h addr=%h", ifu_rsp_valid, ifu_rsp_err, ifu_rsp_data, seen_araddr);
    end
  endtask

  // u1: fixed LSU priority with 64-bit writes, then a 64-bit IFU fetch.
  task automatic test_fixed_priority_64();
    @(negedge clk); #1;
    b_lsu_req_valid = 1; b_lsu_req_wen = 1; b_lsu_addr = 32'h0000_3000;
    b_lsu_wdata = 64'h1122_3344_5566_7788; b_lsu_wstrb = 8'hF0; b_lsu_size = 3'd3;
    b_ifu_req_valid = 1; b_ifu_addr = 32'h8000_0008;
    #1;
    assertions++;
    if ({b_lsu_req_ready, b_ifu_req_ready} !== 2'b10) begin
      failures++; $display("FAIL fp_grant1: lsu,ifu ready=%b want 10", {b_lsu_req_ready, b_ifu_req_ready});
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      if (k == 1) b_lsu_req_valid = 0;
      assertions++;
      if ({b_awvalid, b_wvalid, b_wlast} !== 3'b111 || b_wstrb !== 8'hF0 ||
          b_wdata !== 64'h1122_3344_5566_7788 || b_awsize !== 3'd3 || b_awid !== 4'd1) begin
        failures++; $display("FAIL fp_wr_%0d: awv=%b wv=%b strb=%h data=%h size=%0d id=%h",
          k, b_awvalid, b_wvalid, b_wstrb, b_wdata, b_awsize, b_awid);
      end
      b_awready = 1; b_wready = 1;
      @(negedge clk); #1;
      b_awready = 0; b_wready = 0;
      b_bvalid = 1; b_bresp = 2'b00; b_bid = 4'd1;
      @(negedge clk); #1;
      b_bvalid = 0;
      assertions++;
      if ({b_lsu_rsp_valid, b_lsu_rsp_err} !== 2'b10) begin
        failures++; $display("FAIL fp_wr_rsp_%0d: v,err=%b want 10", k, {b_lsu_rsp_valid, b_lsu_rsp_err});
      end
      assertions++;
      if ({b_lsu_req_ready, b_ifu_req_ready} !== (k == 0 ? 2'b10 : 2'b01)) begin
        failures++; $display("FAIL fp_grant_after_%0d: lsu,ifu ready=%b want %b",
          k, {b_lsu_req_ready, b_ifu_req_ready}, (k == 0 ? 2'b10 : 2'b01));
      end
    end
    @(negedge clk); #1;
    b_ifu_req_valid = 0;
    assertions++;
    if (b_arvalid !== 1'b1 || b_arsize !== 3'd3 || b_arid !== 4'd0 || b_araddr !== 32'h8000_0008) begin
      failures++; $display("FAIL fp_ar64: v=%b size=%0d id=%h addr=%h want 1 3 0 80000008", b_arvalid, b_arsize, b_arid, b_araddr);
    end
    b_arready = 1;
    @(negedge clk); #1;
    b_arready = 0;
    b_rvalid = 1; b_rdata = 64'h0123_4567_89AB_CDEF; b_rresp = 2'b00; b_rid = 4'd0; b_rlast = 1;
    @(negedge clk); #1;
    b_rvalid = 0; b_rlast = 0;
    assertions++;
    if ({b_ifu_rsp_valid, b_ifu_rsp_err} !== 2'b10 || b_ifu_rsp_data !== 64'h0123_4567_89AB_CDEF) begin
      failures++; $display("FAIL fp_rd64: v=%b err=%b data=%h want 1 0 0123456789abcdef",
        b_ifu_rsp_valid, b_ifu_rsp_err, b_ifu_rsp_data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_ifu_read();
    test_write_delayed_aw();
    test_errors();
    test_reset_mid();
    test_fixed_priority_64();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
